// File: rtl/v_state_tbl_if.sv
// ---------------------------------------------------------------------------
// v_state_tbl_if
// Bus bundle for the context-state table: one update read port, Q query read
// ports and one shared write port.
//
// Parameters
//   N  number of contexts (sets the address width AW = $clog2(N))
//   W  state word width
//   Q  number of query read ports
//
// Signals (direction as seen by the table, i.e. the slave modport)
//   i_upd_ren    in   1      update-port read enable
//   i_upd_raddr  in   AW     update-port read address
//   o_upd_vld_r  out  1      update-port read data valid
//   o_upd_rdata  out  W      update-port read data
//   i_qry_ren    in   Q      per-query-port read enable
//   i_qry_raddr  in   Q*AW   query addresses, port q at [q*AW +: AW]
//   o_qry_vld_r  out  Q      per-query-port read data valid
//   o_qry_rdata  out  Q*W    query read data, port q at [q*W +: W]
//   i_wen        in   1      write enable
//   i_waddr      in   AW     write address
//   i_wdata      in   W      write data
//   o_wr_drop_r  out  1      pulse: write discarded because table was busy
// ---------------------------------------------------------------------------
interface v_state_tbl_if #(
    parameter int N = 64,
    parameter int W = 32,
    parameter int Q = 2
);
    localparam int AW = $clog2(N);

    logic            i_upd_ren;
    logic [AW-1:0]   i_upd_raddr;
    logic            o_upd_vld_r;
    logic [W-1:0]    o_upd_rdata;

    logic [Q-1:0]    i_qry_ren;
    logic [Q*AW-1:0] i_qry_raddr;
    logic [Q-1:0]    o_qry_vld_r;
    logic [Q*W-1:0]  o_qry_rdata;

    logic            i_wen;
    logic [AW-1:0]   i_waddr;
    logic [W-1:0]    i_wdata;
    logic            o_wr_drop_r;

    modport slave (
        input  i_upd_ren, i_upd_raddr,
        output o_upd_vld_r, o_upd_rdata,
        input  i_qry_ren, i_qry_raddr,
        output o_qry_vld_r, o_qry_rdata,
        input  i_wen, i_waddr, i_wdata,
        output o_wr_drop_r
    );

    modport master (
        output i_upd_ren, i_upd_raddr,
        input  o_upd_vld_r, o_upd_rdata,
        output i_qry_ren, i_qry_raddr,
        input  o_qry_vld_r, o_qry_rdata,
        output i_wen, i_waddr, i_wdata,
        input  o_wr_drop_r
    );
endinterface

// File: rtl/v_state_tbl.sv
// ---------------------------------------------------------------------------
// v_state_tbl
// Context-state table holding per-context list state for the update and query
// pipes. Q+1 identical 1R1W banks receive every write; bank 0 serves the
// update read port, bank q+1 serves query port q, so all read ports are
// independent and never conflict. An init sequencer writes INIT_VAL to every
// entry after reset and on request; while it runs the table reports busy,
// drops user writes and suppresses read valids.
//
// Reads have one cycle of latency and are write-first: a read that coincides
// with an accepted write to the same address returns the new data. Addresses
// at or beyond N read back INIT_VAL and silently ignore writes.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   i_init_req   in   pulse: re-initialise the whole table (honoured when idle)
//   o_busy_r     out  init sequence in progress
//   bus          slave modport of v_state_tbl_if (read ports, write port,
//                read valids/data, write-drop pulse)
//
// The interface instance must be built with the same N, W and Q.
// ---------------------------------------------------------------------------
module v_state_tbl #(
    parameter int          N        = 64,
    parameter int          W        = 32,
    parameter int          Q        = 2,
    parameter logic [W-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_init_req,
    output logic          o_busy_r,
    v_state_tbl_if.slave  bus
);
    localparam int AW = $clog2(N);
    localparam int P  = Q + 1;      // total read ports / banks

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_nxt;
    logic          wr_drop_r;

    // Bank write port (shared by init sequencer and user writes)
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_wdata;
    logic          usr_wr;

    // Flattened view of all read ports: port 0 = update, port q+1 = query q
    logic [P-1:0]    ren_all;
    logic [P*AW-1:0] raddr_all;
    logic [P-1:0]    vld_all;
    logic [P*W-1:0]  rdata_all;

    // Non-power-of-2 N leaves a hole at the top of the address space.
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(N);
    endfunction

    // ------------------------------------------------------------------
    // Init sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == AW'(N - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_r + AW'(1);
                end
            end
            ST_IDLE: begin
                if (i_init_req) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_INIT;
            cnt_r     <= '0;
            o_busy_r  <= 1'b1;
            wr_drop_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            // busy mirrors the next state so it rises/falls with the FSM
            o_busy_r  <= (state_nxt == ST_INIT);
            wr_drop_r <= bus.i_wen && o_busy_r;
        end
    end

    assign bus.o_wr_drop_r = wr_drop_r;

    // ------------------------------------------------------------------
    // Write arbitration: the sequencer owns the banks while busy
    // ------------------------------------------------------------------
    assign usr_wr = bus.i_wen && !o_busy_r && in_range(bus.i_waddr);

    always_comb begin
        mem_we    = usr_wr;
        mem_waddr = bus.i_waddr;
        mem_wdata = bus.i_wdata;
        if (state_r == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_r;
            mem_wdata = INIT_VAL;
        end
    end

    assign ren_all   = {bus.i_qry_ren, bus.i_upd_ren};
    assign raddr_all = {bus.i_qry_raddr, bus.i_upd_raddr};

    // ------------------------------------------------------------------
    // Replicated banks, one per read port
    // ------------------------------------------------------------------
    for (genvar p = 0; p < P; p++) begin : g_bank
        logic [W-1:0]  mem [N];
        logic          ren;
        logic [AW-1:0] raddr;
        logic          vld_p1;
        logic [W-1:0]  rdata_p1;

        assign ren   = ren_all[p];
        assign raddr = raddr_all[p*AW +: AW];

        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
        end

        // ---- read stage p0 -> p1 ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1   <= 1'b0;
                rdata_p1 <= '0;
            end else begin
                vld_p1 <= ren && !o_busy_r;
                if (ren) begin
                    if (!in_range(raddr)) begin
                        rdata_p1 <= INIT_VAL;
                    end else if (usr_wr && (bus.i_waddr == raddr)) begin
                        // write-first bypass: array still holds the old word
                        rdata_p1 <= bus.i_wdata;
                    end else begin
                        rdata_p1 <= mem[raddr];
                    end
                end
            end
        end

        assign vld_all[p]           = vld_p1;
        assign rdata_all[p*W +: W] = rdata_p1;
    end

    assign bus.o_upd_vld_r = vld_all[0];
    assign bus.o_upd_rdata = rdata_all[W-1:0];
    assign bus.o_qry_vld_r = vld_all[P-1:1];
    assign bus.o_qry_rdata = rdata_all[P*W-1:W];

endmodule
